// File: rtl/lc4_regfile.sv
// LC4 register file: eight n-bit registers with combinational, write-bypassed reads
// and a 3-bit NZP condition register derived from the write data.
module lc4_regfile #(
    parameter int unsigned n     = 16,
    parameter int unsigned nregs = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         gwe,
    input  logic [2:0]   i_rs,
    output logic [n-1:0] o_rs_data,
    input  logic [2:0]   i_rt,
    output logic [n-1:0] o_rt_data,
    input  logic [2:0]   i_rd,
    input  logic [n-1:0] i_wdata,
    input  logic         i_rd_we,
    input  logic         i_nzp_we,
    output logic [2:0]   o_nzp
);

    logic [n-1:0] regs_q [nregs];
    logic [2:0]   nzp_q;
    logic [2:0]   nzp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(nregs); i++) begin
                regs_q[i] <= '0;
            end
        end else if (gwe && i_rd_we) begin
            regs_q[i_rd] <= i_wdata;
        end
    end

    // Two's-complement sign test: exactly one of N, Z, P is set.
    always_comb begin
        nzp_d = 3'b001;
        if (i_wdata[n-1]) begin
            nzp_d = 3'b100;
        end else if (i_wdata == '0) begin
            nzp_d = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_q <= 3'b000;
        end else if (gwe && i_nzp_we) begin
            nzp_q <= nzp_d;
        end
    end

    // Bypass ignores gwe and reset so the ALU sees the value being written this cycle.
    always_comb begin
        o_rs_data = regs_q[i_rs];
        o_rt_data = regs_q[i_rt];
        if (i_rd_we && (i_rd == i_rs)) begin
            o_rs_data = i_wdata;
        end
        if (i_rd_we && (i_rd == i_rt)) begin
            o_rt_data = i_wdata;
        end
    end

    assign o_nzp = nzp_q;

endmodule

// File: tb/tb_lc4_regfile.sv
// Directed bench for lc4_regfile: reset, write/readback, bypass, gwe gating, NZP, full sweep.
module tb_lc4_regfile;

    logic        clk;
    logic        rst_n;
    logic        gwe;
    logic [2:0]  i_rs;
    logic [15:0] o_rs_data;
    logic [2:0]  i_rt;
    logic [15:0] o_rt_data;
    logic [2:0]  i_rd;
    logic [15:0] i_wdata;
    logic        i_rd_we;
    logic        i_nzp_we;
    logic [2:0]  o_nzp;

    int passed;
    int total;

    lc4_regfile #(
        .n     (16),
        .nregs (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gwe       (gwe),
        .i_rs      (i_rs),
        .o_rs_data (o_rs_data),
        .i_rt      (i_rt),
        .o_rt_data (o_rt_data),
        .i_rd      (i_rd),
        .i_wdata   (i_wdata),
        .i_rd_we   (i_rd_we),
        .i_nzp_we  (i_nzp_we),
        .o_nzp     (o_nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs are then driven well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gwe = 1'b1; i_rd_we = 1'b0; i_nzp_we = 1'b0;
        i_rs = 3'd0; i_rt = 3'd0; i_rd = 3'd0; i_wdata = 16'h0000;
        tick(); tick();
        total++;
        if (o_nzp !== 3'b000 || o_rs_data !== 16'h0000)
            $display("FAIL reset_initial: nzp=%b rs=%h, required nzp=000 rs=0000", o_nzp, o_rs_data);
        else passed++;
        rst_n = 1'b1;
        // R3=1234 with an NZP update (positive).
        i_rd = 3'd3; i_wdata = 16'h1234; i_rd_we = 1'b1; i_nzp_we = 1'b1;
        tick();
        i_rd_we = 1'b0; i_nzp_we = 1'b0; i_rs = 3'd3;
        #1;
        total++;
        if (o_rs_data !== 16'h1234 || o_nzp !== 3'b001)
            $display("FAIL reset_prewrite: rs=%h nzp=%b, required rs=1234 nzp=001", o_rs_data, o_nzp);
        else passed++;
        // Asynchronous assert mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (o_rs_data !== 16'h0000 || o_nzp !== 3'b000)
            $display("FAIL reset_async: rs=%h nzp=%b, required rs=0000 nzp=000", o_rs_data, o_nzp);
        else passed++;
        // Bypass forwards during reset; edges during reset must not write.
        i_rd_we = 1'b1; i_nzp_we = 1'b1; i_rd = 3'd3; i_wdata = 16'hABCD;
        #1;
        total++;
        if (o_rs_data !== 16'hABCD)
            $display("FAIL reset_bypass: rs=%h, required abcd", o_rs_data);
        else passed++;
        tick();
        i_rd_we = 1'b0; i_nzp_we = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (o_rs_data !== 16'h0000 || o_nzp !== 3'b000)
            $display("FAIL reset_no_write: rs=%h nzp=%b, required rs=0000 nzp=000", o_rs_data, o_nzp);
        else passed++;
    endtask

    task automatic test_write_readback();
        gwe = 1'b1; i_rd = 3'd5; i_wdata = 16'hBEEF; i_rd_we = 1'b1; i_nzp_we = 1'b0;
        tick();
        i_rd_we = 1'b0; i_rs = 3'd5; i_rt = 3'd5;
        #1;
        total++;
        if (o_rs_data !== 16'hBEEF || o_rt_data !== 16'hBEEF)
            $display("FAIL readback_r5: rs=%h rt=%h, required beef", o_rs_data, o_rt_data);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            if (k != 5) begin
                i_rs = 3'(k);
                #1;
                total++;
                if (o_rs_data !== 16'h0000)
                    $display("FAIL readback_other_r%0d: got %h, required 0000", k, o_rs_data);
                else passed++;
            end
        end
    endtask

    task automatic test_bypass();
        i_rd = 3'd2; i_wdata = 16'h0001; i_rd_we = 1'b1;
        tick();
        i_rd_we = 1'b1; i_rd = 3'd2; i_wdata = 16'h00FF; i_rt = 3'd2; i_rs = 3'd5;
        #1;
        total++;
        if (o_rt_data !== 16'h00FF || o_rs_data !== 16'hBEEF)
            $display("FAIL bypass_rt: rt=%h rs=%h, required rt=00ff rs=beef", o_rt_data, o_rs_data);
        else passed++;
        i_rs = 3'd2;
        #1;
        total++;
        if (o_rs_data !== 16'h00FF)
            $display("FAIL bypass_rs: rs=%h, required 00ff", o_rs_data);
        else passed++;
        i_rd_we = 1'b0;
        #1;
        total++;
        if (o_rt_data !== 16'h0001 || o_rs_data !== 16'h0001)
            $display("FAIL bypass_off: rt=%h rs=%h, required 0001", o_rt_data, o_rs_data);
        else passed++;
        // Bypass while gwe=0, and R0 is writable.
        gwe = 1'b0; i_rd_we = 1'b1; i_rd = 3'd0; i_wdata = 16'h5A5A; i_rs = 3'd0;
        #1;
        total++;
        if (o_rs_data !== 16'h5A5A)
            $display("FAIL bypass_gwe0: rs=%h, required 5a5a", o_rs_data);
        else passed++;
        gwe = 1'b1;
        tick();
        i_rd_we = 1'b0;
        #1;
        total++;
        if (o_rs_data !== 16'h5A5A)
            $display("FAIL r0_writable: rs=%h, required 5a5a", o_rs_data);
        else passed++;
    endtask

    task automatic test_gwe();
        gwe = 1'b1; i_nzp_we = 1'b1; i_rd_we = 1'b0; i_wdata = 16'h0005;
        tick();
        gwe = 1'b0; i_rd_we = 1'b1; i_nzp_we = 1'b1; i_rd = 3'd7; i_wdata = 16'h8000;
        tick();
        gwe = 1'b1; i_rd_we = 1'b0; i_nzp_we = 1'b0; i_rs = 3'd7;
        #1;
        total++;
        if (o_rs_data !== 16'h0000 || o_nzp !== 3'b001)
            $display("FAIL gwe_gate: r7=%h nzp=%b, required r7=0000 nzp=001", o_rs_data, o_nzp);
        else passed++;
    endtask

    task automatic test_nzp();
        logic [15:0] vals [3];
        logic [2:0]  exp_nzp [3];
        vals[0] = 16'hFFFF; exp_nzp[0] = 3'b100;
        vals[1] = 16'h0000; exp_nzp[1] = 3'b010;
        vals[2] = 16'h7FFF; exp_nzp[2] = 3'b001;
        for (int k = 0; k < 3; k++) begin
            gwe = 1'b1; i_rd_we = 1'b0; i_nzp_we = 1'b1; i_rd = 3'd6; i_wdata = vals[k];
            tick();
            i_nzp_we = 1'b0; i_rs = 3'd6; i_rt = 3'd5;
            #1;
            total++;
            if (o_nzp !== exp_nzp[k] || o_rs_data !== 16'h0000 || o_rt_data !== 16'hBEEF)
                $display("FAIL nzp_%0d: nzp=%b r6=%h r5=%h, required nzp=%b r6=0000 r5=beef",
                         k, o_nzp, o_rs_data, o_rt_data, exp_nzp[k]);
            else passed++;
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_rs;
        logic [15:0] exp_rt;
        gwe = 1'b1; i_nzp_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_rd_we = 1'b1; i_rd = 3'(k); i_wdata = 16'(16'h1111 * k);
            tick();
        end
        i_rd_we = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                i_rs = 3'(a); i_rt = 3'(b);
                #1;
                exp_rs = 16'(16'h1111 * a);
                exp_rt = 16'(16'h1111 * b);
                total++;
                if (o_rs_data !== exp_rs || o_rt_data !== exp_rt)
                    $display("FAIL sweep_%0d_%0d: rs=%h rt=%h, required rs=%h rt=%h",
                             a, b, o_rs_data, o_rt_data, exp_rs, exp_rt);
                else passed++;
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_write_readback();
        test_bypass();
        test_gwe();
        test_nzp();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
